// File: rtl/traffic_pkg.sv
// Shared types and default timing for the two-way intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_NSG,
        S_NSY,
        S_AR1,
        S_EWG,
        S_EWY,
        S_AR2,
        S_WALK
    } state_t;

    localparam int DEF_GREEN_TIME  = 25;
    localparam int DEF_YELLOW_TIME = 5;
    localparam int DEF_ALLRED_TIME = 2;
    localparam int DEF_WALK_TIME   = 10;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamp_t;

    localparam lamp_t LAMP_RED    = 3'b100;
    localparam lamp_t LAMP_YELLOW = 3'b010;
    localparam lamp_t LAMP_GREEN  = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; holds at zero and only moves on enabled cycles.
module phase_timer #(
    parameter int              CW        = 16,
    parameter logic [CW-1:0]   RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          done
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= RESET_VAL;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/intersection_controller.sv
// Two-way intersection sequencer with an inserted pedestrian walk phase.
import traffic_pkg::*;

module intersection_controller #(
    parameter int GREEN_TIME  = DEF_GREEN_TIME,
    parameter int YELLOW_TIME = DEF_YELLOW_TIME,
    parameter int ALLRED_TIME = DEF_ALLRED_TIME,
    parameter int WALK_TIME   = DEF_WALK_TIME,
    parameter int CW          = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic PED_REQ,
    output logic NS_RED,
    output logic NS_YELLOW,
    output logic NS_GREEN,
    output logic EW_RED,
    output logic EW_YELLOW,
    output logic EW_GREEN,
    output logic PED_WALK,
    output logic PED_PENDING
);

    localparam longint MAX_TIME = (longint'(1) << CW) - 1;

    if (GREEN_TIME < 1 || longint'(GREEN_TIME) > MAX_TIME) begin : g_bad_green
        $error("GREEN_TIME out of range");
    end
    if (YELLOW_TIME < 1 || longint'(YELLOW_TIME) > MAX_TIME) begin : g_bad_yellow
        $error("YELLOW_TIME out of range");
    end
    if (ALLRED_TIME < 1 || longint'(ALLRED_TIME) > MAX_TIME) begin : g_bad_allred
        $error("ALLRED_TIME out of range");
    end
    if (WALK_TIME < 1 || longint'(WALK_TIME) > MAX_TIME) begin : g_bad_walk
        $error("WALK_TIME out of range");
    end

    localparam logic [CW-1:0] G_LOAD  = CW'(GREEN_TIME - 1);
    localparam logic [CW-1:0] Y_LOAD  = CW'(YELLOW_TIME - 1);
    localparam logic [CW-1:0] AR_LOAD = CW'(ALLRED_TIME - 1);
    localparam logic [CW-1:0] W_LOAD  = CW'(WALK_TIME - 1);

    state_t        state_reg, state_next;
    logic          pending_reg, pending_next;
    logic          next_dir_reg, next_dir_next;   // 1: EW green follows walk
    logic          done;
    logic          advance;
    logic [CW-1:0] load_val;
    lamp_t         ns_lamp, ew_lamp;

    assign advance = EN && done;

    phase_timer #(
        .CW        (CW),
        .RESET_VAL (G_LOAD)
    ) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (advance),
        .load_val (load_val),
        .en       (EN),
        .done     (done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= S_NSG;
            pending_reg  <= 1'b0;
            next_dir_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            next_dir_reg <= next_dir_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        next_dir_next = next_dir_reg;
        if (advance) begin
            case (state_reg)
                S_NSG: state_next = S_NSY;
                S_NSY: state_next = S_AR1;
                S_AR1: begin
                    next_dir_next = 1'b1;
                    state_next    = pending_reg ? S_WALK : S_EWG;
                end
                S_EWG: state_next = S_EWY;
                S_EWY: state_next = S_AR2;
                S_AR2: begin
                    next_dir_next = 1'b0;
                    state_next    = pending_reg ? S_WALK : S_NSG;
                end
                S_WALK: state_next = next_dir_reg ? S_EWG : S_NSG;
                default: state_next = S_NSG;
            endcase
        end
    end

    // Load value is always for the state being entered; only used on advance.
    always_comb begin
        load_val = G_LOAD;
        case (state_next)
            S_NSG, S_EWG: load_val = G_LOAD;
            S_NSY, S_EWY: load_val = Y_LOAD;
            S_AR1, S_AR2: load_val = AR_LOAD;
            S_WALK:       load_val = W_LOAD;
            default:      load_val = G_LOAD;
        endcase
    end

    // Walk entry wins over a simultaneous request; requests in walk are dropped.
    always_comb begin
        pending_next = pending_reg;
        if (state_reg != S_WALK) begin
            if (state_next == S_WALK) begin
                pending_next = 1'b0;
            end else if (PED_REQ) begin
                pending_next = 1'b1;
            end
        end
    end

    always_comb begin
        ns_lamp  = LAMP_RED;
        ew_lamp  = LAMP_RED;
        PED_WALK = 1'b0;
        case (state_reg)
            S_NSG:  ns_lamp  = LAMP_GREEN;
            S_NSY:  ns_lamp  = LAMP_YELLOW;
            S_EWG:  ew_lamp  = LAMP_GREEN;
            S_EWY:  ew_lamp  = LAMP_YELLOW;
            S_WALK: PED_WALK = 1'b1;
            default: ;
        endcase
    end

    assign {NS_RED, NS_YELLOW, NS_GREEN} = ns_lamp;
    assign {EW_RED, EW_YELLOW, EW_GREEN} = ew_lamp;
    assign PED_PENDING = pending_reg;

    assert property (@(posedge CLK) disable iff (RST)
        !((NS_GREEN || NS_YELLOW) && (EW_GREEN || EW_YELLOW))
        && $onehot({NS_RED, NS_YELLOW, NS_GREEN})
        && $onehot({EW_RED, EW_YELLOW, EW_GREEN}));

endmodule
